// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory write bundle for the program loader.
// The host side uses master; the loader itself uses slave.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_left;

  modport master (
    output start, in_byte, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_left
  );

  modport slave (
    input  start, in_byte, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_left
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as little-endian 32-bit words.
// Frame: LEN_LO, LEN_HI (word count N), then 4*N data bytes; oversize frames are rejected.
module imem_loader #(
  parameter int DEPTH  = 148,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  localparam int         WIDX_W    = ADDR_W - 2;
  localparam logic [15:0] MAX_WORDS = 16'(DEPTH / 4);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         shift_q, shift_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [15:0]         words_left_q, words_left_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                take;
  logic [15:0]         len_word;

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    word_idx_d   = word_idx_q;
    words_left_d = words_left_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    take         = bus.in_valid & in_ready_q;
    len_word     = {bus.in_byte, len_lo_q};

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_d    = LEN0;
          word_idx_d = '0;
        end
      end
      LEN0: begin
        if (take) begin
          len_lo_d = bus.in_byte;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        // The length check up front is what keeps every write address inside the memory.
        if (take) begin
          if (len_word == 16'd0) begin
            state_d = DONE;
          end else if (len_word > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d      = DATA;
            words_left_d = len_word;
            byte_idx_d   = 2'd0;
            word_idx_d   = '0;
          end
        end
      end
      DATA: begin
        // The write cycle stalls input; the frame finishes only after the last strobe.
        if (mem_we_q) begin
          if (words_left_q == 16'd0) begin
            state_d = DONE;
          end
        end else if (take) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: shift_d[7:0]   = bus.in_byte;
            2'd1: shift_d[15:8]  = bus.in_byte;
            2'd2: shift_d[23:16] = bus.in_byte;
            2'd3: begin
              mem_we_d     = 1'b1;
              mem_addr_d   = {word_idx_q, 2'b00};
              mem_wdata_d  = {bus.in_byte, shift_q};
              word_idx_d   = word_idx_q + WIDX_W'(1);
              words_left_d = words_left_q - 16'd1;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
    in_ready_d = busy_d && !mem_we_d;
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      word_idx_q   <= '0;
      words_left_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      word_idx_q   <= word_idx_d;
      words_left_q <= words_left_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.words_left = words_left_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a frame-level model (byte counts, word arithmetic) is compared against
// the DUT every cycle, with literal checks on the memory image and handshake at key points.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.DEPTH(148), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Frame-level model: tracks how many bytes of the current frame were taken and derives
  // every output from that count, the word count N and the number of words written.
  bit          m_init   = 1'b0;
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_err    = 1'b0;
  bit          m_wr     = 1'b0;
  int          m_cnt    = 0;
  int          m_n      = 0;
  int          m_writes = 0;
  int          m_waddr  = 0;
  logic [7:0]  m_lo;
  logic [7:0]  m_buf [4];
  logic [31:0] m_wdata;
  logic [31:0] exp_mem [64];

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1'b1; m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_wr = 1'b0;
      m_cnt = 0; m_n = 0; m_writes = 0;
    end else if (m_wr) begin
      m_wr = 1'b0;
      if (m_writes == m_n) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (m_active && bus.in_valid) begin
      m_cnt++;
      if (m_cnt == 1) begin
        m_lo = bus.in_byte;
      end else if (m_cnt == 2) begin
        m_n = int'({bus.in_byte, m_lo});
        if (m_n == 0) begin
          m_active = 1'b0; m_done = 1'b1;
        end else if (m_n > 148 / 4) begin
          m_active = 1'b0; m_err = 1'b1;
        end
      end else begin
        m_buf[(m_cnt - 3) % 4] = bus.in_byte;
        if ((m_cnt - 3) % 4 == 3) begin
          m_wr    = 1'b1;
          m_waddr = ((m_cnt - 3) / 4) * 4;
          m_wdata = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          exp_mem[(m_cnt - 3) / 4] = m_wdata;
          m_writes++;
        end
      end
    end else if (!m_active && bus.start) begin
      m_active = 1'b1; m_done = 1'b0; m_err = 1'b0;
      m_cnt = 0; m_n = 0; m_writes = 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("in_ready",   bus.in_ready,   m_active && !m_wr);
      check("mem_we",     bus.mem_we,     m_wr);
      check("busy",       bus.busy,       m_active);
      check("done",       bus.done,       m_done);
      check("error",      bus.error,      m_err);
      check("words_left", bus.words_left,
            (m_active && m_cnt >= 2) ? 32'(m_n - m_writes) : 32'd0);
      if (m_wr) begin
        check("mem_addr",  bus.mem_addr,  32'(m_waddr));
        check("mem_wdata", bus.mem_wdata, m_wdata);
      end
    end
  end

  logic [31:0] dut_mem [64];
  int          write_count = 0;
  int          last_addr   = -1;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      dut_mem[bus.mem_addr[7:2]] = bus.mem_wdata;
      last_addr = int'(bus.mem_addr);
      write_count++;
    end
  end

  logic [7:0] frame_q [$];
  int         wr_base;

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit taken = 1'b0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk); #1;
        taken = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!taken) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic apply_stimulus(input bit gap);
    foreach (frame_q[i]) begin
      send_byte(frame_q[i]);
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_finish(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      settle();
      if (bus.done === 1'b1 || bus.error === 1'b1) seen = 1'b1;
    end
    if (!seen) check("wait_finish_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    settle();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);

    // Two-word program
    wr_base = write_count;
    pulse_start();
    frame_q = {8'h02, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00, 8'h93, 8'h0E, 8'h60, 8'h00};
    apply_stimulus(1'b0);
    wait_finish(10);
    check("t1_done", bus.done, 1'b1);
    check("t1_busy", bus.busy, 1'b0);
    check("t1_words_left", bus.words_left, 32'd0);
    check("t1_writes", 32'(write_count - wr_base), 32'd2);
    check("t1_mem0", dut_mem[0], 32'h00600593);
    check("t1_mem1", dut_mem[1], 32'h00600E93);
    check("t1_model_mem0", exp_mem[0], 32'h00600593);
    check("t1_model_mem1", exp_mem[1], 32'h00600E93);

    // Zero-length frame
    wr_base = write_count;
    pulse_start();
    frame_q = {8'h00, 8'h00};
    apply_stimulus(1'b0);
    settle();
    check("t2_done", bus.done, 1'b1);
    check("t2_in_ready", bus.in_ready, 1'b0);
    check("t2_writes", 32'(write_count - wr_base), 32'd0);

    // Oversize frame, then recovery
    wr_base = write_count;
    pulse_start();
    frame_q = {8'h26, 8'h00};
    apply_stimulus(1'b0);
    repeat (3) settle();
    check("t3_error", bus.error, 1'b1);
    check("t3_in_ready", bus.in_ready, 1'b0);
    check("t3_writes_err", 32'(write_count - wr_base), 32'd0);
    pulse_start();
    frame_q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    apply_stimulus(1'b0);
    wait_finish(10);
    check("t3_error_clear", bus.error, 1'b0);
    check("t3_writes", 32'(write_count - wr_base), 32'd1);
    check("t3_addr", 32'(last_addr), 32'd0);
    check("t3_mem0", dut_mem[0], 32'h12345678);

    // Gapped stream, latency of the write strobe
    wr_base = write_count;
    pulse_start();
    frame_q = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD};
    apply_stimulus(1'b1);
    send_byte(8'hDE);
    check("t4_we_latency", bus.mem_we, 1'b1);
    check("t4_wdata", bus.mem_wdata, 32'hDEADBEEF);
    wait_finish(10);
    check("t4_writes", 32'(write_count - wr_base), 32'd1);

    // Reset in the middle of the second word
    wr_base = write_count;
    pulse_start();
    frame_q = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    apply_stimulus(1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    settle();
    check("t5_busy", bus.busy, 1'b0);
    check("t5_done", bus.done, 1'b0);
    check("t5_in_ready", bus.in_ready, 1'b0);
    check("t5_addr", bus.mem_addr, 32'd0);
    check("t5_wdata", bus.mem_wdata, 32'd0);
    check("t5_words_left", bus.words_left, 32'd0);
    check("t5_writes", 32'(write_count - wr_base), 32'd1);
    check("t5_mem0", dut_mem[0], 32'h44332211);

    // Full 37-word image with a stray start in the middle
    wr_base = write_count;
    pulse_start();
    frame_q = {8'h25, 8'h00};
    for (int i = 0; i < 10; i++) frame_q.push_back(8'(i * 5 + 1));
    apply_stimulus(1'b0);
    pulse_start();
    frame_q = {};
    for (int i = 10; i < 148; i++) frame_q.push_back(8'(i * 5 + 1));
    apply_stimulus(1'b0);
    wait_finish(10);
    check("t6_done", bus.done, 1'b1);
    check("t6_writes", 32'(write_count - wr_base), 32'd37);
    check("t6_last_addr", 32'(last_addr), 32'd144);
    check("t6_mem36", dut_mem[36], 32'hE0DBD6D1);
    check("t6_model_mem36", exp_mem[36], 32'hE0DBD6D1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
